bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on `x`. A qualifying strobe and an end-of-word pulse go with each bit. The downstream detector samples `x` on every `clk` rising edge, and `x` is held at 0 between words so idle time looks like a run of zeros.

---
 rtl/bit_serializer.sv | 163 ++++++++++++++++
 tb/tb_bit_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer
//  Purpose  : Parallel-to-serial front end for the serial sequence detector.
//             Accepts WIDTH-bit words over a valid/ready handshake and shifts
//             them out MSB-first, one bit per clock, on x. Between words x is
//             held at 0, so idle time looks like a run of zeros downstream.
//  Ports    : clk        - clock, all flops on the rising edge
//             rst        - asynchronous, active-low reset
//             din        - parallel word, sampled on the accepting edge
//             din_valid  - upstream word available
//             din_ready  - block can accept a word this cycle (combinational
//                          from state/counter only)
//             x          - serial bit (registered)
//             x_valid    - x carries a real data/parity bit (registered)
//             word_done  - one-cycle pulse on the final bit of a word
//  Options  : SER_PARITY_EN - when defined, an even-parity bit follows bit 0
//             of every word; word_done and din_ready move to that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               word_done_q, word_done_d;
    logic               last_bit;
    logic               accept;
`ifdef SER_PARITY_EN
    logic               par_q, par_d;
`endif

    // The bit currently on x is the last data bit when the counter is 0.
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);

`ifdef SER_PARITY_EN
    assign din_ready = (state_q == ST_IDLE) || (state_q == ST_PAR);
`else
    assign din_ready = (state_q == ST_IDLE) || last_bit;
`endif

    assign accept = din_valid && din_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        x_d         = 1'b0;
        x_valid_d   = 1'b0;
        word_done_d = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    // shreg_q holds the bits still to send, MSB first.
                    x_d       = shreg_q[WIDTH-1];
                    x_valid_d = 1'b1;
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d     = cnt_q - CNT_W'(1);
`ifdef SER_PARITY_EN
                    word_done_d = 1'b0;
`else
                    // Next bit out is bit 0: flag it as the end of the word.
                    word_done_d = (cnt_q == CNT_W'(1));
`endif
                end else begin
`ifdef SER_PARITY_EN
                    state_d     = ST_PAR;
                    x_d         = par_q;
                    x_valid_d   = 1'b1;
                    word_done_d = 1'b1;
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            ST_PAR: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new word can only arrive in IDLE or the final-bit cycle, so it
        // overrides whatever the current word would have done next. The MSB
        // is presented right away, leaving the remaining bits in shreg.
        if (accept) begin
            state_d     = ST_SHIFT;
            x_d         = din[WIDTH-1];
            x_valid_d   = 1'b1;
            word_done_d = 1'b0;
            shreg_d     = {din[WIDTH-2:0], 1'b0};
            cnt_d       = CNT_W'(WIDTH-1);
`ifdef SER_PARITY_EN
            par_d       = ^din;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign word_done = word_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer
//  Purpose  : Directed self-checking bench for bit_serializer (WIDTH = 8).
//             Builds with or without SER_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       x;
    logic       x_valid;
    logic       word_done;

    int errors = 0;
    int checks = 0;

    bit_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // Reset behaviour, no capture during reset, then 20 idle cycles.
    task automatic test_reset();
        din = 8'hFF;
        din_valid = 1'b1;
        #1;
        checks++;
        if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state: got x/v/done/rdy=%b expected 0001", {x, x_valid, word_done, din_ready});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_no_capture: got x/v/done/rdy=%b expected 0001", {x, x_valid, word_done, din_ready});
        end
        din_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL idle_cycle%0d: got x/v/done/rdy=%b expected 0001", i, {x, x_valid, word_done, din_ready});
            end
        end
    endtask

    // Send one word and check the full serial stream. exp holds the data
    // bits MSB-first in [8:1] and the expected parity bit in [0].
    task automatic send_word(input logic [7:0] w, input logic [8:0] exp, input string nm);
        logic [3:0] want;
        din = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            want = {exp[8-i], 1'b1, (i == NB-1), (i == NB-1)};
            checks++;
            if ({x, x_valid, word_done, din_ready} !== want) begin
                errors++;
                $display("FAIL %s_bit%0d: got x/v/done/rdy=%b expected %b", nm, i, {x, x_valid, word_done, din_ready}, want);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL %s_idle_after: got x/v/done/rdy=%b expected 0001", nm, {x, x_valid, word_done, din_ready});
        end
    endtask

    task automatic test_single_words();
        send_word(8'hB4, 9'b1011_0100_0, "word_B4");
        send_word(8'h07, 9'b0000_0111_1, "word_07");
    endtask

    // FF then 00 with din_valid held: contiguous valid bits, no bubble.
    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [3:0]  want;
        logic        fin;
`ifdef SER_PARITY_EN
        exp = {9'b1111_1111_0, 9'b0000_0000_0};
`else
        exp = {8'hFF, 8'h00, 2'b00};
`endif
        din = 8'hFF;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din = 8'h00;
        for (int i = 0; i < 2*NB; i++) begin
            fin  = ((i % NB) == NB-1);
            want = {exp[17-i], 1'b1, fin, fin};
            checks++;
            if ({x, x_valid, word_done, din_ready} !== want) begin
                errors++;
                $display("FAIL b2b_bit%0d: got x/v/done/rdy=%b expected %b", i, {x, x_valid, word_done, din_ready}, want);
            end
            if (i == 2*NB-1) din_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_idle_after: got x/v/done/rdy=%b expected 0001", {x, x_valid, word_done, din_ready});
        end
    endtask

    // A din_valid pulse while busy must not disturb the current word.
    task automatic test_ignore_busy();
        logic [8:0] exp;
        logic [3:0] want;
        exp = 9'b0011_1100_0;
        din = 8'h3C;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            want = {exp[8-i], 1'b1, (i == NB-1), (i == NB-1)};
            checks++;
            if ({x, x_valid, word_done, din_ready} !== want) begin
                errors++;
                $display("FAIL ignore_bit%0d: got x/v/done/rdy=%b expected %b", i, {x, x_valid, word_done, din_ready}, want);
            end
            if (i == 3) begin
                din = 8'hAA;
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL ignore_idle_after: got x/v/done/rdy=%b expected 0001", {x, x_valid, word_done, din_ready});
        end
    endtask

    // Asynchronous reset after three bits of C3, then a clean word 81.
    task automatic test_reset_mid_word();
        logic [7:0] exp;
        exp = 8'hC3;
        din = 8'hC3;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({x, x_valid, word_done} !== {exp[7-i], 2'b10}) begin
                errors++;
                $display("FAIL rstmid_bit%0d: got x/v/done=%b expected %b", i, {x, x_valid, word_done}, {exp[7-i], 2'b10});
            end
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_async_drop: got x/v/done/rdy=%b expected 0001", {x, x_valid, word_done, din_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({x, x_valid, word_done, din_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL rstmid_release%0d: got x/v/done/rdy=%b expected 0001", i, {x, x_valid, word_done, din_ready});
            end
        end
        send_word(8'h81, 9'b1000_0001_0, "word_81");
    endtask

    initial begin
        test_reset();
        test_single_words();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
